// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one operand bit per clock, LSB first
//
// Purpose:
//    Adds or subtracts two WIDTH-bit operands using a single full-adder cell
//    and a carry flip-flop. An operation takes WIDTH clocks in RUN followed by
//    a one-cycle DONE state in which a new operation may already be accepted.
//
// Ports:
//    clk    - system clock, rising edge
//    reset  - synchronous, active-high reset
//    start  - request a new operation (honoured in IDLE or DONE only)
//    sub    - 0: a+b, 1: a-b; latched at accept
//    a, b   - operands, latched at accept
//    busy   - high while bits are being processed
//    done   - one-cycle pulse; results valid from this cycle onward
//    sum    - result register
//    cout   - carry out of the MSB (in subtract mode 1 means no borrow)
//    ovf    - two's-complement overflow
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cmsb;
   logic             s;
   logic             c;
   logic             accept;

   // The single full-adder cell.
   always_comb begin
      s = opa[0] ^ opb[0] ^ carry;
      c = (opa[0] & opb[0]) | ((opa[0] ^ opb[0]) & carry);
   end

   always_comb begin
      accept = start && ((state == S_IDLE) || (state == S_DONE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == LAST_BIT) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opa   <= '0;
         opb   <= '0;
         sreg  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         cmsb  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         opa   <= {1'b0, opa[WIDTH-1:1]};
         opb   <= {1'b0, opb[WIDTH-1:1]};
         sreg  <= {s, sreg[WIDTH-1:1]};
         carry <= c;
         cnt   <= cnt + 1'b1;
         // Carry leaving bit WIDTH-2 is the carry into the MSB, needed for ovf.
         if (cnt == MSB_CIN_BIT) cmsb <= c;
         // Result registers only move here, so they hold across later RUNs.
         if (cnt == LAST_BIT) begin
            sum  <= {s, sreg[WIDTH-1:1]};
            cout <= c;
            ovf  <= cmsb ^ c;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - scoreboard testbench for serial_addsub (WIDTH=8)
module tb_serial_addsub;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   serial_addsub #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic msub);
      exp_t       e;
      logic [8:0] r;
      if (msub) r = {1'b0, ma} + {1'b0, ~mb} + 9'd1;
      else      r = {1'b0, ma} + {1'b0, mb};
      e.sum  = r[7:0];
      e.cout = r[8];
      if (msub) e.ovf = (ma[7] != mb[7]) && (r[7] != ma[7]);
      else      e.ovf = (ma[7] == mb[7]) && (r[7] != ma[7]);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (expq.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("sum",  {24'd0, sum}, {24'd0, e.sum});
            check("cout", {31'd0, cout}, {31'd0, e.cout});
            check("ovf",  {31'd0, ovf}, {31'd0, e.ovf});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        input logic push, input exp_t e, output int acc_cyc);
      a     = ia;
      b     = ib;
      sub   = isub;
      start = 1'b1;
      if (push) expq.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_done(output int dcyc, output int nbusy);
      int n;
      n     = 0;
      nbusy = busy ? 1 : 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n = n + 1;
         if (busy) nbusy = nbusy + 1;
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
      dcyc = cyc;
   endtask

   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub, input exp_t e);
      int acc;
      int dc;
      int nb;
      issue(ia, ib, isub, 1'b1, e, acc);
      wait_done(dc, nb);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int         acc;
      int         dc;
      int         nb;
      int         first_done;
      int         done_seen;
      logic [7:0] vals[14];

      reset = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum",  {24'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf",  {31'd0, ovf}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic add with latency, busy length and done width.
      issue(8'h3C, 8'h0F, 1'b0, 1'b1, '{sum: 8'h4B, cout: 1'b0, ovf: 1'b0}, acc);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(dc, nb);
      check("latency", dc - acc, 8);
      check("busy_cycles", nb, 8);
      @(negedge clk);
      check("done_width", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Carry / overflow / subtract corners, hand-computed.
      run_op(8'hFF, 8'h01, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
      run_op(8'h7F, 8'h01, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
      run_op(8'h05, 8'h07, 1'b1, '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0});
      run_op(8'h80, 8'h01, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});
      run_op(8'h10, 8'h10, 1'b1, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
      check("hold_sum_idle", {24'd0, sum}, 32'h00);
      check("hold_cout_idle", {31'd0, cout}, 32'd1);

      // Input isolation: disturb inputs and pulse start during RUN.
      issue(8'h3C, 8'h0F, 1'b0, 1'b1, '{sum: 8'h4B, cout: 1'b0, ovf: 1'b0}, acc);
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      sub   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("hold_sum_run", {24'd0, sum}, 32'h00);
      wait_done(dc, nb);
      check("isolation_latency", dc - acc, 8);
      first_done = dc;

      // Back-to-back accept in DONE.
      a     = 8'h12;
      b     = 8'h34;
      sub   = 1'b0;
      start = 1'b1;
      expq.push_back('{sum: 8'h46, cout: 1'b0, ovf: 1'b0});
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_done(dc, nb);
      check("b2b_period", dc - first_done, 9);
      @(negedge clk);
      check("b2b_idle", {31'd0, busy}, 32'd0);

      // Reset after four bits of AA+55: no done, outputs cleared.
      issue(8'hAA, 8'h55, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b0, ovf: 1'b0}, acc);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_sum",  {24'd0, sum}, 32'd0);
      check("abort_cout", {31'd0, cout}, 32'd0);
      check("abort_ovf",  {31'd0, ovf}, 32'd0);
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_seen = done_seen + 1;
      end
      check("abort_no_done", done_seen, 0);
      run_op(8'h01, 8'h01, 1'b0, '{sum: 8'h02, cout: 1'b0, ovf: 1'b0});

      // Boundary-heavy operand sweep against the reference model.
      vals = '{8'h00, 8'h01, 8'h0F, 8'h3C, 8'h55, 8'h7E, 8'h7F,
               8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < 14; j++) begin
               run_op(vals[i], vals[j], m[0], model(vals[i], vals[j], m[0]));
            end
         end
      end

      repeat (3) @(negedge clk);
      check("queue_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
